vram_arbiter: RTL and testbench

Sequences the single-port 16 KB video SRAM between three requesters on the 14 MHz domain: the ULA video fetcher (bitmap/attribute reads), the Z80 (reads and writes to 4000h–7FFFh), and an optional DMA/snapshot loader. It owns every SRAM control pin and turns each granted request into a fixed, glitch-free SRAM read or write cycle. It returns read data through registered per-requester ports with a one-cycle acknowledge. It sits between the ULA timing generator, the CPU contention logic and the SRAM pads.

---
 rtl/vram_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter - single-port 16 KB video SRAM sequencer for the 14 MHz domain.
//
// Arbitrates the ULA video fetcher, the Z80 and (optionally) a DMA/snapshot
// loader onto one asynchronous SRAM. Each grant becomes a fixed read cycle
// (RD1, RD2) or write cycle (WR_SETUP, WR_PULSE x WE_CYCLES, WR_HOLD). All
// SRAM pins come straight from registers. Acks are one-cycle pulses issued in
// the IDLE cycle that follows a transaction; read data is held in registers.
//
// Optional feature macro: VRAM_ARBITER_DMA_EN (adds the DMA port, its grant
// path and the DMA starvation counter).
//
// Ports:
//   clk14, reset                  clock, asynchronous active-high reset
//   vid_req/addr -> vid_ack/data  video read port
//   cpu_req/we/addr/wdata         CPU port -> cpu_ack, cpu_rdata, cpu_wait
//   dma_req/we/addr/wdata         DMA port -> dma_ack, dma_rdata (macro only)
//   sram_a, sram_dq_o, sram_dq_i  SRAM address / data
//   sram_cs, sram_oe, sram_we     active-high SRAM controls
module vram_arbiter #(
    parameter int AW        = 14,
    parameter int WE_CYCLES = 1
) (
    input  logic          clk14,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_wait,
`ifdef VRAM_ARBITER_DMA_EN
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ack,
    output logic [7:0]    dma_rdata,
`endif
    output logic [AW-1:0] sram_a,
    output logic [7:0]    sram_dq_o,
    input  logic [7:0]    sram_dq_i,
    output logic          sram_cs,
    output logic          sram_oe,
    output logic          sram_we
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_DMA} owner_t;

    state_t        r_state;
    owner_t        r_owner;
    logic [1:0]    r_we_cnt;
    logic [AW-1:0] r_sram_a;
    logic [7:0]    r_sram_dq_o;
    logic          r_sram_cs;
    logic          r_sram_oe;
    logic          r_sram_we;
    logic          r_vid_ack;
    logic          r_cpu_ack;
    logic [7:0]    r_vid_data;
    logic [7:0]    r_cpu_rdata;
`ifdef VRAM_ARBITER_DMA_EN
    logic          r_dma_ack;
    logic [7:0]    r_dma_rdata;
    logic [2:0]    r_starve;
`endif

    logic          w_gnt_valid;
    owner_t        w_gnt;
    logic [AW-1:0] w_gnt_addr;
    logic          w_gnt_we;
    logic [7:0]    w_gnt_wdata;

    // Grant selection: video > starved DMA > CPU > DMA; only acted upon in IDLE.
    always_comb begin
        w_gnt_valid = 1'b1;
        w_gnt       = OWN_VID;
        w_gnt_addr  = vid_addr;
        w_gnt_we    = 1'b0;     // video is always a read
        w_gnt_wdata = cpu_wdata;
        if (vid_req) begin
            w_gnt = OWN_VID;
        end
`ifdef VRAM_ARBITER_DMA_EN
        else if (dma_req && (r_starve == 3'd4)) begin
            w_gnt       = OWN_DMA;
            w_gnt_addr  = dma_addr;
            w_gnt_we    = dma_we;
            w_gnt_wdata = dma_wdata;
        end
`endif
        else if (cpu_req) begin
            w_gnt       = OWN_CPU;
            w_gnt_addr  = cpu_addr;
            w_gnt_we    = cpu_we;
            w_gnt_wdata = cpu_wdata;
        end
`ifdef VRAM_ARBITER_DMA_EN
        else if (dma_req) begin
            w_gnt       = OWN_DMA;
            w_gnt_addr  = dma_addr;
            w_gnt_we    = dma_we;
            w_gnt_wdata = dma_wdata;
        end
`endif
        else begin
            w_gnt_valid = 1'b0;
        end
    end

    // Transaction FSM: owns every SRAM pin, read-data registers and acks.
    always_ff @(posedge clk14 or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_VID;
            r_we_cnt    <= 2'd0;
            r_sram_a    <= {AW{1'b0}};
            r_sram_dq_o <= 8'h00;
            r_sram_cs   <= 1'b0;
            r_sram_oe   <= 1'b0;
            r_sram_we   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_vid_data  <= 8'h00;
            r_cpu_rdata <= 8'h00;
`ifdef VRAM_ARBITER_DMA_EN
            r_dma_ack   <= 1'b0;
            r_dma_rdata <= 8'h00;
`endif
        end else begin
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
`ifdef VRAM_ARBITER_DMA_EN
            r_dma_ack <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner   <= w_gnt;
                        r_sram_a  <= w_gnt_addr;
                        r_sram_cs <= 1'b1;
                        if (w_gnt_we) begin
                            r_sram_dq_o <= w_gnt_wdata;
                            r_state     <= WR_SETUP;
                        end else begin
                            r_sram_oe <= 1'b1;
                            r_state   <= RD1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD1: r_state <= RD2;
                RD2: begin
                    // Async SRAM data has settled over two cycles of stable drive.
                    r_sram_cs <= 1'b0;
                    r_sram_oe <= 1'b0;
                    r_state   <= IDLE;
                    case (r_owner)
                        OWN_VID: begin
                            r_vid_data <= sram_dq_i;
                            r_vid_ack  <= 1'b1;
                        end
                        OWN_CPU: begin
                            r_cpu_rdata <= sram_dq_i;
                            r_cpu_ack   <= 1'b1;
                        end
`ifdef VRAM_ARBITER_DMA_EN
                        OWN_DMA: begin
                            r_dma_rdata <= sram_dq_i;
                            r_dma_ack   <= 1'b1;
                        end
`endif
                        default: r_state <= IDLE;
                    endcase
                end
                WR_SETUP: begin
                    r_sram_we <= 1'b1;
                    r_we_cnt  <= 2'(WE_CYCLES - 1);
                    r_state   <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (r_we_cnt == 2'd0) begin
                        r_sram_we <= 1'b0;
                        r_state   <= WR_HOLD;
                    end else begin
                        r_we_cnt <= r_we_cnt - 2'd1;
                    end
                end
                WR_HOLD: begin
                    r_sram_cs <= 1'b0;
                    r_state   <= IDLE;
                    case (r_owner)
                        OWN_CPU: r_cpu_ack <= 1'b1;
`ifdef VRAM_ARBITER_DMA_EN
                        OWN_DMA: r_dma_ack <= 1'b1;
`endif
                        default: r_state <= IDLE;
                    endcase
                end
                default: begin
                    r_sram_cs <= 1'b0;
                    r_sram_oe <= 1'b0;
                    r_sram_we <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_ARBITER_DMA_EN
    // Consecutive CPU grants while DMA waits; at 4 the DMA wins the next grant.
    always_ff @(posedge clk14 or posedge reset) begin
        if (reset) begin
            r_starve <= 3'd0;
        end else if (!dma_req) begin
            r_starve <= 3'd0;
        end else if ((r_state == IDLE) && w_gnt_valid && (w_gnt == OWN_DMA)) begin
            r_starve <= 3'd0;
        end else if ((r_state == IDLE) && w_gnt_valid && (w_gnt == OWN_CPU) && (r_starve != 3'd4)) begin
            r_starve <= r_starve + 3'd1;
        end else begin
            r_starve <= r_starve;
        end
    end

    assign dma_ack   = r_dma_ack;
    assign dma_rdata = r_dma_rdata;
`endif

    assign vid_ack   = r_vid_ack;
    assign vid_data  = r_vid_data;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    // Combinational so the contention logic stretches the CPU in cycle 0 already.
    assign cpu_wait  = cpu_req & ~r_cpu_ack & ~reset;
    assign sram_a    = r_sram_a;
    assign sram_dq_o = r_sram_dq_o;
    assign sram_cs   = r_sram_cs;
    assign sram_oe   = r_sram_oe;
    assign sram_we   = r_sram_we;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios followed by random
// requester traffic, all checked every cycle against a transaction-level model.
module tb_vram_arbiter;
    localparam int AW = 14;
    localparam int W  = 2;
`ifdef VRAM_ARBITER_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif

    logic clk14 = 1'b0;
    always #5 clk14 = ~clk14;

    logic          reset;
    // requester index: 0 = video, 1 = CPU, 2 = DMA
    logic          rq   [3];
    logic          rwe  [3];
    logic [AW-1:0] radr [3];
    logic [7:0]    rwd  [3];

    logic          vid_ack, cpu_ack, cpu_wait;
    logic [7:0]    vid_data, cpu_rdata;
    logic [AW-1:0] sram_a;
    logic [7:0]    sram_dq_o, sram_dq_i;
    logic          sram_cs, sram_oe, sram_we;
`ifdef VRAM_ARBITER_DMA_EN
    logic          dma_ack;
    logic [7:0]    dma_rdata;
`endif

    vram_arbiter #(.AW(AW), .WE_CYCLES(W)) dut (
        .clk14(clk14), .reset(reset),
        .vid_req(rq[0]), .vid_addr(radr[0]), .vid_ack(vid_ack), .vid_data(vid_data),
        .cpu_req(rq[1]), .cpu_we(rwe[1]), .cpu_addr(radr[1]), .cpu_wdata(rwd[1]),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
`ifdef VRAM_ARBITER_DMA_EN
        .dma_req(rq[2]), .dma_we(rwe[2]), .dma_addr(radr[2]), .dma_wdata(rwd[2]),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
`endif
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we)
    );

    // Asynchronous SRAM model
    logic [7:0] sram [0:(1<<AW)-1];
    assign sram_dq_i = sram[sram_a];
    always @(posedge clk14) if (sram_we) sram[sram_a] = sram_dq_o;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0]    ref_mem [0:(1<<AW)-1];
    int            pos, len, own, starve;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wd;
    logic          m_we;
    logic          e_ack [3];
    logic [7:0]    e_rd  [3];
    logic          e_cs, e_oe, e_we;
    logic [AW-1:0] e_a;
    logic [7:0]    e_dq;

    task automatic model_reset();
        pos = 0; len = 0; own = 0; starve = 0; m_we = 1'b0;
        for (int i = 0; i < 3; i++) begin e_ack[i] = 1'b0; e_rd[i] = 8'h00; end
        e_cs = 1'b0; e_oe = 1'b0; e_we = 1'b0; e_a = '0; e_dq = 8'h00;
    endtask

    // Decide what the edge at the end of the current cycle produces.
    task automatic model_step();
        int win;
        for (int i = 0; i < 3; i++) e_ack[i] = 1'b0;
        if (pos != 0) begin
            if (pos == len) begin
                e_ack[own] = 1'b1;
                if (m_we) ref_mem[m_addr] = m_wd;
                else      e_rd[own] = ref_mem[m_addr];
                pos = 0;
            end else begin
                pos++;
            end
        end else begin
            win = -1;
            if (rq[0])                              win = 0;
            else if (DMA_EN && rq[2] && starve == 4) win = 2;
            else if (rq[1])                         win = 1;
            else if (DMA_EN && rq[2])               win = 2;
            if (win >= 0) begin
                own    = win;
                m_addr = radr[win];
                m_we   = (win != 0) && rwe[win];
                m_wd   = rwd[win];
                len    = m_we ? 2 + W : 2;
                pos    = 1;
                e_a    = m_addr;
                if (m_we) e_dq = m_wd;
                if (win == 1 && rq[2]) starve = (starve < 4) ? starve + 1 : 4;
                else if (win == 2)     starve = 0;
            end
        end
        if (!DMA_EN || !rq[2]) starve = 0;
        e_cs = (pos != 0);
        e_oe = (pos != 0) && !m_we;
        e_we = (pos >= 2) && m_we && (pos <= 1 + W);
    endtask

    task automatic check_outputs();
        check_eq("vid_ack", vid_ack, e_ack[0]);
        check_eq("cpu_ack", cpu_ack, e_ack[1]);
        check_eq("vid_data", vid_data, e_rd[0]);
        check_eq("cpu_rdata", cpu_rdata, e_rd[1]);
        check_eq("sram_cs", sram_cs, e_cs);
        check_eq("sram_oe", sram_oe, e_oe);
        check_eq("sram_we", sram_we, e_we);
        check_eq("oe_we_excl", sram_oe & sram_we, 1'b0);
        check_eq("cpu_wait", cpu_wait, rq[1] & ~e_ack[1] & ~reset);
        if (e_cs) check_eq("sram_a", sram_a, e_a);
        if (e_cs && m_we) check_eq("sram_dq_o", sram_dq_o, e_dq);
`ifdef VRAM_ARBITER_DMA_EN
        check_eq("dma_ack", dma_ack, e_ack[2]);
        check_eq("dma_rdata", dma_rdata, e_rd[2]);
`endif
    endtask

    bit hold_reqs = 1'b0;

    // One clock: advance model with the final inputs, clock, check, drop acked reqs.
    task automatic tick();
        if (reset) model_reset(); else model_step();
        @(posedge clk14);
        #1;
        cyc++;
        check_outputs();
        if (!hold_reqs)
            for (int i = 0; i < 3; i++) if (e_ack[i]) rq[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        rq[i] = 1'b1; rwe[i] = we; radr[i] = a; rwd[i] = d;
    endtask

    int         oe_cnt, t_vid, t_cpu, lat, ngr;
    logic [5:1] we_seq, cs_seq, oe_seq;
    logic [9:0] order, exp_order;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin rq[i] = 1'b0; rwe[i] = 1'b0; radr[i] = '0; rwd[i] = 8'h00; end
        for (int i = 0; i < (1 << AW); i++) begin sram[i] = 8'($urandom); ref_mem[i] = sram[i]; end
        sram[14'h1800] = 8'h5A; ref_mem[14'h1800] = 8'h5A;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Idle single read
        set_req(1, 1'b0, 14'h1800, 8'h00);
        #1;
        check_eq("rd_wait_c0", cpu_wait, 1'b1);
        oe_cnt = 0;
        tick(); oe_cnt += int'(sram_oe); check_eq("rd_wait_c1", cpu_wait, 1'b1);
        tick(); oe_cnt += int'(sram_oe); check_eq("rd_wait_c2", cpu_wait, 1'b1);
        tick(); oe_cnt += int'(sram_oe);
        check_eq("rd_ack_c3", cpu_ack, 1'b1);
        check_eq("rd_data_c3", cpu_rdata, 8'h5A);
        repeat (2) begin tick(); oe_cnt += int'(sram_oe); end
        check_eq("rd_oe_cycles", oe_cnt, 2);

        // Write pulse shape
        set_req(1, 1'b1, 14'h0000, 8'hC3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            we_seq[k] = sram_we; cs_seq[k] = sram_cs; oe_seq[k] = sram_oe;
            if (k == 5) check_eq("wr_ack_c5", cpu_ack, 1'b1);
        end
        check_eq("wr_we_shape", we_seq, 5'b00110);
        check_eq("wr_cs_shape", cs_seq, 5'b01111);
        check_eq("wr_oe_shape", oe_seq, 5'b00000);
        check_eq("wr_sram0", sram[0], 8'hC3);
        repeat (2) tick();

        // Video priority over simultaneous CPU request
        set_req(0, 1'b0, 14'h0000, 8'h00);
        set_req(1, 1'b0, 14'h1800, 8'h00);
        t_vid = -1; t_cpu = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (vid_ack && t_vid < 0) t_vid = k;
            if (cpu_ack && t_cpu < 0) t_cpu = k;
        end
        check_eq("prio_vid_ack", t_vid, 3);
        check_eq("prio_cpu_ack", t_cpu, 6);
        check_eq("prio_vid_data", vid_data, 8'hC3);

        // Video arriving one cycle after a CPU write grant
        set_req(1, 1'b1, 14'h1803, 8'h3C);
        tick();
        set_req(0, 1'b0, 14'h1803, 8'h00);
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (vid_ack) lat = k;
        end
        check_eq("vid_behind_wr_lat", lat, 5 + W);
        check_eq("vid_behind_wr_data", vid_data, 8'h3C);
        repeat (2) tick();

`ifdef VRAM_ARBITER_DMA_EN
        // Starvation: CPU and DMA both held high continuously
        hold_reqs = 1'b1;
        set_req(1, 1'b0, 14'h1801, 8'h00);
        set_req(2, 1'b0, 14'h1802, 8'h00);
        ngr = 0; order = '0; exp_order = 10'b1000010000;
        for (int k = 0; k < 100 && ngr < 10; k++) begin
            tick();
            if (dma_ack) begin order[ngr] = 1'b1; ngr++; end
            else if (cpu_ack) begin order[ngr] = 1'b0; ngr++; end
        end
        check_eq("starve_count", ngr, 10);
        check_eq("starve_order", order, exp_order);
        rq[1] = 1'b0; rq[2] = 1'b0;
        hold_reqs = 1'b0;
        repeat (8) tick();
`endif

        // Reset during WR_PULSE
        set_req(1, 1'b1, 14'h0005, 8'h77);
        tick(); tick();
        check_eq("mid_wr_we_before", sram_we, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("mid_wr_we_async", sram_we, 1'b0);
        check_eq("mid_wr_cs_async", sram_cs, 1'b0);
        check_eq("mid_wr_wait_rst", cpu_wait, 1'b0);
        model_reset();
        repeat (2) tick();
        rq[1] = 1'b0;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check_eq("mid_wr_lost", sram[5], ref_mem[5]);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (i == 2 && !DMA_EN) continue;
                if (!rq[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), 14'h1800 + 14'($urandom_range(0, 7)), 8'($urandom));
                else if (rq[i] && $urandom_range(0, 15) == 0)
                    rq[i] = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
